io_port_fx: RTL
===============

# io_port_fx

Buffered I/O responder for the stack processor's IN/OUT instructions. It sits between the instruction decoder's `req_in`/`out_en` strobes and the external world. An input FIFO collects words from an external producer and presents the head word on `io_in`. An output FIFO captures the accumulator on each OUT and drains it to an external consumer over a valid/ready handshake.

## Interface

Parameters:
- `NBDATA`, 32, data word width (matches processor datapath)
- `DEPTH`, 8, entries per FIFO; power of two, ≥ 2
- `ADDRW`, 3, log2(`DEPTH`); pointers are `ADDRW+1` bits

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  reset; asynchronous, active-low (asserted when 0)
- `req_in`  in  1  from decoder; each cycle high = one IN pop
- `io_in`  out  NBDATA  input FIFO head word, to decoder `io_in`
- `out_en`  in  1  from decoder; each cycle high = one OUT push
- `acc_data`  in  NBDATA  accumulator value captured on `out_en`
- `in_data`  in  NBDATA  external producer word
- `in_valid`  in  1  producer has a word
- `in_ready`  out  1  input FIFO can accept a word
- `out_data`  out  NBDATA  output FIFO head word to consumer
- `out_valid`  out  1  output FIFO non-empty
- `out_ready`  in  1  consumer accepts `out_data`
- `in_count`  out  ADDRW+1  input FIFO occupancy, 0..DEPTH
- `out_count`  out  ADDRW+1  output FIFO occupancy, 0..DEPTH
- `in_underflow`  out  1  sticky: IN issued while input FIFO empty
- `out_overflow`  out  1  sticky: OUT issued while output FIFO full
- `clr_flags`  in  1  synchronous clear of both sticky flags

## Operation

- Two independent circular FIFOs, each with write/read pointers of `ADDRW+1` bits.
- Occupancy is `wr_ptr - rd_ptr` (modulo `2^(ADDRW+1)`).
- Empty when the pointers are equal. Full when the MSBs differ and the low bits are equal.

Input FIFO:
- Push when `in_valid && in_ready`.
- `in_ready = !in_full`. It depends on registered state only; there is no combinational path from `req_in`.
- `io_in` is the head word when non-empty, and 0 when empty. It is combinational from the read pointer.
- A pop occurs on each edge with `req_in` high and the FIFO non-empty.
- `req_in` with the FIFO empty: no pointer change, `io_in` = 0, `in_underflow` set.
- Push and pop in the same cycle when non-empty and not full: both occur; count unchanged.
- Empty with a simultaneous push and `req_in`: underflow is flagged, 0 is returned, and the pushed word is stored (count becomes 1).

Output FIFO:
- Push `acc_data` on each edge with `out_en` high and the FIFO not full.
- `out_en` with the FIFO full: the word is dropped and `out_overflow` is set. This holds even if `out_ready` pops in the same cycle; there is no bypass.
- Pop when `out_valid && out_ready`.
- `out_valid = !out_empty`. `out_data` is the head word when valid, and 0 otherwise.

Flags:
- `clr_flags` clears both sticky flags.
- If a set condition and `clr_flags` occur in the same cycle, set wins.

Reset (`rst` = 0, async):
- Pointers, counts and flags go to 0.
- `in_ready` = 1, `out_valid` = 0, `io_in` = 0, `out_data` = 0.
- FIFO storage contents are not reset.
- Reset mid-transfer discards all buffered words.

## Timing

- `io_in` is valid in the same cycle `req_in` rises. The decoder samples it through `ula_data` in that cycle, and the pop takes effect at the closing edge.
- `req_in` held high N consecutive cycles produces N pops. Consecutive INs return consecutive words.
- Producer-to-`io_in` latency: 1 cycle. A word pushed at edge k is visible on `io_in` after edge k.
- `acc_data` is sampled at the edge with `out_en` high. It appears on `out_data` after that edge, giving 1-cycle latency to `out_valid`.
- `in_count`, `out_count` and the flags are registered and update at the edge following the event.

## Configuration

- `IO_ERR_FLAG_EN` defined: the `in_underflow` and `out_overflow` sticky registers and `clr_flags` are implemented as described.
- `IO_ERR_FLAG_EN` undefined:
  - Both flag outputs are tied to 0 and `clr_flags` is ignored.
  - Underflow still returns 0 with no pop.
  - Overflow still drops the word.

## Test plan

- Reset, then push 0x11, 0x22, 0x33 via `in_valid`. Pulse `req_in` 3 single cycles. `io_in` reads 0x11, 0x22, 0x33; `in_count` goes 3 → 0.
- Hold `req_in` high 2 cycles with 2 words buffered (0xA, 0xB). `io_in` reads 0xA then 0xB. A third `req_in` cycle gives `io_in` = 0 and `in_underflow` = 1. `clr_flags` then clears it.
- Push `DEPTH` words via `in_valid` with no `req_in`. `in_ready` drops to 0 after the 8th word and the 9th word is not accepted. One `req_in` pop restores `in_ready` = 1.
- `out_en` with `acc_data` = 0xDEADBEEF and `out_ready` = 0. `out_valid` = 1 and `out_data` = 0xDEADBEEF next cycle. Raising `out_ready` for 1 cycle drains it, leaving `out_valid` = 0.
- Issue 9 `out_en` cycles with `acc_data` = 1..9 and `out_ready` = 0. `out_count` = 8 and `out_overflow` = 1. The drain yields 1..8; word 9 is lost. Without `IO_ERR_FLAG_EN`, the same data results and `out_overflow` stays 0.
- With 4 words buffered in each FIFO, drive `rst` low mid-cycle. Outputs go to reset values immediately (async). After release, `in_count` = `out_count` = 0 and `in_ready` = 1.

Source files
------------

// File: rtl/io_port_fx_if.sv
// Bus bundle for io_port_fx: decoder strobes, producer/consumer handshakes,
// occupancy counts and error flags.
interface io_port_fx_if #(
  parameter int unsigned NBDATA = 32,
  parameter int unsigned ADDRW  = 3
);
  logic              req_in;
  logic [NBDATA-1:0] io_in;
  logic              out_en;
  logic [NBDATA-1:0] acc_data;
  logic [NBDATA-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [NBDATA-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDRW:0]    in_count;
  logic [ADDRW:0]    out_count;
  logic              in_underflow;
  logic              out_overflow;
  logic              clr_flags;

  modport master (
    output req_in, out_en, acc_data, in_data, in_valid, out_ready, clr_flags,
    input  io_in, in_ready, out_data, out_valid, in_count, out_count,
           in_underflow, out_overflow
  );

  modport slave (
    input  req_in, out_en, acc_data, in_data, in_valid, out_ready, clr_flags,
    output io_in, in_ready, out_data, out_valid, in_count, out_count,
           in_underflow, out_overflow
  );
endinterface

// File: rtl/io_port_fx.sv
// Buffered IN/OUT responder: input FIFO feeding the decoder, output FIFO draining OUT words.
// Optional sticky error flags are built when IO_ERR_FLAG_EN is defined.
module io_port_fx #(
  parameter int unsigned NBDATA = 32,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDRW  = 3
) (
  input  logic        clk,
  input  logic        rst,
  io_port_fx_if.slave bus
);
  localparam int unsigned PW = ADDRW + 1;

  logic [PW-1:0]     in_wr, in_rd, out_wr, out_rd;
  logic [PW-1:0]     in_cnt, out_cnt;
  logic [NBDATA-1:0] in_mem  [DEPTH];
  logic [NBDATA-1:0] out_mem [DEPTH];

  logic in_empty_c, in_full_c, out_empty_c, out_full_c;
  logic in_push_c, in_pop_c, out_push_c, out_pop_c;

  // Full/empty from pointer MSB and low-bit comparison
  always_comb begin
    in_empty_c  = (in_wr == in_rd);
    in_full_c   = (in_wr[ADDRW] != in_rd[ADDRW]) &&
                  (in_wr[ADDRW-1:0] == in_rd[ADDRW-1:0]);
    out_empty_c = (out_wr == out_rd);
    out_full_c  = (out_wr[ADDRW] != out_rd[ADDRW]) &&
                  (out_wr[ADDRW-1:0] == out_rd[ADDRW-1:0]);
    in_push_c   = bus.in_valid && !in_full_c;
    in_pop_c    = bus.req_in && !in_empty_c;
    out_push_c  = bus.out_en && !out_full_c;
    out_pop_c   = bus.out_ready && !out_empty_c;
  end

  // Pointers and occupancy; an OUT into a full FIFO is dropped even if the
  // consumer pops in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_wr   <= '0;
      in_rd   <= '0;
      out_wr  <= '0;
      out_rd  <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (in_push_c)  in_wr  <= in_wr + PW'(1);
      if (in_pop_c)   in_rd  <= in_rd + PW'(1);
      if (out_push_c) out_wr <= out_wr + PW'(1);
      if (out_pop_c)  out_rd <= out_rd + PW'(1);
      in_cnt  <= in_cnt + PW'(in_push_c) - PW'(in_pop_c);
      out_cnt <= out_cnt + PW'(out_push_c) - PW'(out_pop_c);
    end
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (in_push_c)  in_mem[in_wr[ADDRW-1:0]]   <= bus.in_data;
    if (out_push_c) out_mem[out_wr[ADDRW-1:0]] <= bus.acc_data;
  end

  assign bus.in_ready  = !in_full_c;
  assign bus.out_valid = !out_empty_c;
  assign bus.io_in     = in_empty_c  ? '0 : in_mem[in_rd[ADDRW-1:0]];
  assign bus.out_data  = out_empty_c ? '0 : out_mem[out_rd[ADDRW-1:0]];
  assign bus.in_count  = in_cnt;
  assign bus.out_count = out_cnt;

`ifdef IO_ERR_FLAG_EN
  logic uf_q, of_q;

  // Sticky flags; a new error in the clearing cycle keeps the flag set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uf_q <= 1'b0;
      of_q <= 1'b0;
    end else begin
      if (bus.req_in && in_empty_c)     uf_q <= 1'b1;
      else if (bus.clr_flags)           uf_q <= 1'b0;
      if (bus.out_en && out_full_c)     of_q <= 1'b1;
      else if (bus.clr_flags)           of_q <= 1'b0;
    end
  end

  assign bus.in_underflow = uf_q;
  assign bus.out_overflow = of_q;
`else
  assign bus.in_underflow = 1'b0;
  assign bus.out_overflow = 1'b0;
`endif
endmodule
